// File: rtl/rs_line_burst_arbiter.sv
// rs_line_burst_arbiter
//   N-to-1 burst arbiter for Reed-Solomon encoder line streams. Each grant forwards
//   NUM_LINES lines from one input without interleaving; the lines go through a small
//   output FIFO and are tagged with their source index and an end-of-burst flag.
//   Selection is either strict index order (waits on an absent input) or
//   work-conserving round-robin starting from the input after the last burst.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   strict_order        1 = strict index order, 0 = round-robin (sampled in idle only)
//   src_line_*          per-input valid / data / parity (flattened) and one-hot ready
//   dst_line_*          output valid / data / parity / source id / last, downstream ready
//   stat_bursts         completed bursts (RS_LINE_ARB_STATS_EN only)
//   stat_stall_cycles   cycles with dst valid held off by dst ready (RS_LINE_ARB_STATS_EN only)
//
// Optional feature: define RS_LINE_ARB_STATS_EN to add the saturating statistics counters.
module rs_line_burst_arbiter #(
  parameter int unsigned NUM_INPUTS = 32,
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned PARITY_W   = 32,
  parameter int unsigned NUM_LINES  = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             strict_order,
  input  logic [NUM_INPUTS-1:0]            src_line_vals,
  input  logic [NUM_INPUTS*DATA_W-1:0]     src_line_datas,
  input  logic [NUM_INPUTS*PARITY_W-1:0]   src_line_parities,
  output logic [NUM_INPUTS-1:0]            src_line_rdys,
  output logic                             dst_line_val,
  output logic [DATA_W-1:0]                dst_line_data,
  output logic [PARITY_W-1:0]              dst_line_parity,
  output logic [((NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1)-1:0] dst_line_src_id,
  output logic                             dst_line_last,
  input  logic                             dst_line_rdy
`ifdef RS_LINE_ARB_STATS_EN
  ,
  output logic [31:0]                      stat_bursts,
  output logic [31:0]                      stat_stall_cycles
`endif
);

  localparam int unsigned ID_W   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned CNT_W  = $clog2(NUM_LINES + 1);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENT_W  = DATA_W + PARITY_W + ID_W + 1;

  typedef enum logic {StIdle, StBurst} state_e;

  state_e            r_state, w_state_d;
  logic [ID_W-1:0]   r_cur, w_cur_d;
  logic [ID_W-1:0]   r_next_ptr, w_next_ptr_d;
  logic [CNT_W-1:0]  r_line_cnt, w_line_cnt_d;

  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [FCNT_W-1:0] r_count;

  logic              w_full, w_push, w_pop, w_last, w_found;
  logic [ID_W-1:0]   w_cand;
  logic [ENT_W-1:0]  w_entry;
  int                w_idx;

  assign w_full = (r_count == FCNT_W'(FIFO_DEPTH));
  assign w_last = (r_line_cnt == CNT_W'(NUM_LINES - 1));
  // Ready comes from registered state and FIFO occupancy only; a same-cycle pop does not
  // free a slot, which keeps dst_line_rdy off the src_line_rdys path.
  assign w_push = (r_state == StBurst) && !w_full && src_line_vals[r_cur];
  assign w_pop  = dst_line_val && dst_line_rdy;
  assign w_entry = {src_line_datas[r_cur*DATA_W +: DATA_W],
                    src_line_parities[r_cur*PARITY_W +: PARITY_W], r_cur, w_last};

  always_comb begin
    src_line_rdys = '0;
    if (r_state == StBurst && !w_full) src_line_rdys[r_cur] = 1'b1;
  end

  // Candidate search. Round-robin scans from the highest offset down so the valid input
  // closest to next_ptr (cyclically) wins.
  always_comb begin
    w_found = 1'b0;
    w_cand  = r_next_ptr;
    w_idx   = 0;
    if (strict_order) begin
      w_found = src_line_vals[r_next_ptr];
    end else begin
      for (int k = int'(NUM_INPUTS) - 1; k >= 0; k--) begin
        w_idx = int'(r_next_ptr) + k;
        if (w_idx >= int'(NUM_INPUTS)) w_idx = w_idx - int'(NUM_INPUTS);
        if (src_line_vals[w_idx]) begin
          w_found = 1'b1;
          w_cand  = ID_W'(w_idx);
        end
      end
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_cur_d      = r_cur;
    w_next_ptr_d = r_next_ptr;
    w_line_cnt_d = r_line_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_d    = StBurst;
          w_cur_d      = w_cand;
          w_line_cnt_d = '0;
        end
      end
      StBurst: begin
        if (w_push) begin
          w_line_cnt_d = r_line_cnt + 1'b1;
          if (w_last) begin
            w_state_d    = StIdle;
            w_next_ptr_d = (r_cur == ID_W'(NUM_INPUTS - 1)) ? '0 : r_cur + 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cur      <= '0;
      r_next_ptr <= '0;
      r_line_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cur      <= w_cur_d;
      r_next_ptr <= w_next_ptr_d;
      r_line_cnt <= w_line_cnt_d;
    end
  end

  // Storage is cleared on reset so every dst output reads zero while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dst_line_val = (r_count != '0);
  assign {dst_line_data, dst_line_parity, dst_line_src_id, dst_line_last} = r_mem[r_rd_ptr];

`ifdef RS_LINE_ARB_STATS_EN
  logic [31:0] r_bursts, r_stalls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bursts <= '0;
      r_stalls <= '0;
    end else begin
      if (w_push && w_last && r_bursts != '1) r_bursts <= r_bursts + 1'b1;
      if (dst_line_val && !dst_line_rdy && r_stalls != '1) r_stalls <= r_stalls + 1'b1;
    end
  end

  assign stat_bursts       = r_bursts;
  assign stat_stall_cycles = r_stalls;
`endif

endmodule

// File: tb/tb_rs_line_burst_arbiter.sv
// Bench for rs_line_burst_arbiter: two instances (4 inputs x 2-line bursts, 3 inputs x
// 4-line bursts). Each source offers a pre-generated random line stream; the expected
// output is built from the grant rules over those streams and compared line by line.
module tb_rs_line_burst_arbiter;
  localparam int DW = 16;
  localparam int PW = 8;
  localparam int NA = 4;
  localparam int LA = 2;
  localparam int NB = 3;
  localparam int LB = 4;
  localparam int DEPTH = 2;
  localparam int SL = 64;
  localparam int EW = DW + PW + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic a_strict, a_dval, a_drdy, a_last;
  logic [NA-1:0] a_vals, a_rdys;
  logic [NA*DW-1:0] a_datas;
  logic [NA*PW-1:0] a_pars;
  logic [DW-1:0] a_ddata;
  logic [PW-1:0] a_dpar;
  logic [1:0] a_id;
  logic b_strict, b_dval, b_drdy, b_last;
  logic [NB-1:0] b_vals, b_rdys;
  logic [NB*DW-1:0] b_datas;
  logic [NB*PW-1:0] b_pars;
  logic [DW-1:0] b_ddata;
  logic [PW-1:0] b_dpar;
  logic [1:0] b_id;
`ifdef RS_LINE_ARB_STATS_EN
  logic [31:0] a_stat_b, a_stat_s, b_stat_b, b_stat_s;
`endif

  rs_line_burst_arbiter #(.NUM_INPUTS(NA), .DATA_W(DW), .PARITY_W(PW), .NUM_LINES(LA),
                          .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .strict_order(a_strict), .src_line_vals(a_vals),
    .src_line_datas(a_datas), .src_line_parities(a_pars), .src_line_rdys(a_rdys),
    .dst_line_val(a_dval), .dst_line_data(a_ddata), .dst_line_parity(a_dpar),
    .dst_line_src_id(a_id), .dst_line_last(a_last), .dst_line_rdy(a_drdy)
`ifdef RS_LINE_ARB_STATS_EN
    , .stat_bursts(a_stat_b), .stat_stall_cycles(a_stat_s)
`endif
  );

  rs_line_burst_arbiter #(.NUM_INPUTS(NB), .DATA_W(DW), .PARITY_W(PW), .NUM_LINES(LB),
                          .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .strict_order(b_strict), .src_line_vals(b_vals),
    .src_line_datas(b_datas), .src_line_parities(b_pars), .src_line_rdys(b_rdys),
    .dst_line_val(b_dval), .dst_line_data(b_ddata), .dst_line_parity(b_dpar),
    .dst_line_src_id(b_id), .dst_line_last(b_last), .dst_line_rdy(b_drdy)
`ifdef RS_LINE_ARB_STATS_EN
    , .stat_bursts(b_stat_b), .stat_stall_cycles(b_stat_s)
`endif
  );

  logic [DW+PW-1:0] a_str [NA][SL];
  logic [DW+PW-1:0] b_str [NB][SL];
  int a_sp [NA];
  int b_sp [NB];
  logic [EW-1:0] a_obs [$];
  logic [EW-1:0] b_obs [$];
  logic [EW-1:0] exp_q [$];
  int a_obt [$];
  int a_acc, cyc;
  logic [NA-1:0] a_rdy_seen;
  int n_tests = 0;
  int n_fail = 0;

  task automatic drive_srcs();
    for (int i = 0; i < NA; i++) begin
      a_datas[i*DW +: DW] = a_str[i][a_sp[i] % SL][DW+PW-1:PW];
      a_pars[i*PW +: PW]  = a_str[i][a_sp[i] % SL][PW-1:0];
    end
    for (int i = 0; i < NB; i++) begin
      b_datas[i*DW +: DW] = b_str[i][b_sp[i] % SL][DW+PW-1:PW];
      b_pars[i*PW +: PW]  = b_str[i][b_sp[i] % SL][PW-1:0];
    end
  endtask

  task automatic new_streams();
    for (int i = 0; i < NA; i++) begin
      a_sp[i] = 0;
      for (int k = 0; k < SL; k++) a_str[i][k] = (DW+PW)'($urandom);
    end
    for (int i = 0; i < NB; i++) begin
      b_sp[i] = 0;
      for (int k = 0; k < SL; k++) b_str[i][k] = (DW+PW)'($urandom);
    end
    a_obs.delete(); b_obs.delete(); a_obt.delete();
    a_acc = 0; a_rdy_seen = '0;
    drive_srcs();
  endtask

  // One clock: note handshakes before the edge, then record/advance just after it.
  task automatic step();
    logic [NA-1:0] ash;
    logic [NB-1:0] bsh;
    logic adh, bdh;
    logic [EW-1:0] ae, be;
    ash = a_vals & a_rdys;
    bsh = b_vals & b_rdys;
    adh = a_dval & a_drdy;
    bdh = b_dval & b_drdy;
    ae = {a_ddata, a_dpar, a_id, a_last};
    be = {b_ddata, b_dpar, b_id, b_last};
    a_rdy_seen = a_rdy_seen | a_rdys;
    @(posedge clk); #1;
    cyc++;
    if (adh) begin a_obs.push_back(ae); a_obt.push_back(cyc); end
    if (bdh) b_obs.push_back(be);
    for (int i = 0; i < NA; i++) if (ash[i]) begin a_sp[i]++; a_acc++; end
    for (int i = 0; i < NB; i++) if (bsh[i]) b_sp[i]++;
    drive_srcs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_vals = '0; b_vals = '0; a_drdy = 1'b1; b_drdy = 1'b1;
    a_strict = 1'b1; b_strict = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    new_streams();
  endtask

  // Grant rule: strict takes next_ptr only if valid; round-robin takes the first valid
  // input at or after next_ptr, cyclically. -1 means no grant.
  function automatic int pick(int ptr, int n, logic [3:0] mask, bit strict);
    if (strict) return mask[ptr] ? ptr : -1;
    for (int k = 0; k < n; k++) if (mask[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  task automatic build_exp(input int inst, input bit strict, input logic [3:0] mask,
                           input int nlines);
    int n, l, ptr, g;
    int mp [4];
    logic [DW+PW-1:0] ln;
    n = (inst == 0) ? NA : NB;
    l = (inst == 0) ? LA : LB;
    for (int i = 0; i < 4; i++) mp[i] = 0;
    exp_q.delete();
    ptr = 0;
    while (exp_q.size() < nlines) begin
      g = pick(ptr, n, mask, strict);
      if (g < 0) break;
      for (int k = 0; k < l; k++) begin
        if (inst == 0) ln = a_str[g][mp[g] % SL];
        else ln = b_str[g][mp[g] % SL];
        mp[g]++;
        exp_q.push_back({ln, 2'(g), k == l - 1});
      end
      ptr = (g + 1) % n;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (a_dval !== 1'b0 || a_rdys !== '0 || a_ddata !== '0 || a_dpar !== '0 ||
        a_id !== '0 || a_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: got val=%b rdys=%b data=%h par=%h id=%0d last=%b want all 0",
               a_dval, a_rdys, a_ddata, a_dpar, a_id, a_last);
    end
    n_tests++;
    if (b_dval !== 1'b0 || b_rdys !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got val=%b rdys=%b want 0", b_dval, b_rdys);
    end
    do_reset();
  endtask

  task automatic test_strict_all_valid();
    do_reset();
    a_strict = 1'b1; a_vals = 4'hF;
    while (a_obs.size() < 16 && cyc < 100000) step();
    build_exp(0, 1'b1, 4'hF, 16);
    n_tests++;
    if (a_obs.size() < 16) begin
      n_fail++;
      $display("FAIL strict_all_count: got %0d lines want 16", a_obs.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_tests++;
        if (a_obs[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL strict_all line %0d: got %h want %h", k, a_obs[k], exp_q[k]);
        end
      end
      n_tests++;
      if (a_obt[15] - a_obt[0] !== 22) begin
        n_fail++;
        $display("FAIL strict_all_timing: got span %0d want 22", a_obt[15] - a_obt[0]);
      end
    end
  endtask

  task automatic test_only_input2();
    int lim;
    do_reset();
    a_strict = 1'b0; a_vals = 4'b0100;
    lim = cyc + 200;
    while (a_obs.size() < 8 && cyc < lim) step();
    build_exp(0, 1'b0, 4'b0100, 8);
    n_tests++;
    if (a_obs.size() < 8) begin
      n_fail++;
      $display("FAIL rr_only2_count: got %0d lines want 8", a_obs.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_tests++;
        if (a_obs[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL rr_only2 line %0d: got %h want %h", k, a_obs[k], exp_q[k]);
        end
      end
      n_tests++;
      if (a_obt[7] - a_obt[0] !== 10) begin
        n_fail++;
        $display("FAIL rr_only2_timing: got span %0d want 10", a_obt[7] - a_obt[0]);
      end
    end
    do_reset();
    a_strict = 1'b1; a_vals = 4'b0100;
    repeat (30) step();
    n_tests++;
    if (a_obs.size() !== 0 || a_rdy_seen !== '0) begin
      n_fail++;
      $display("FAIL strict_only2: got lines=%0d rdys_seen=%b want 0 and 0",
               a_obs.size(), a_rdy_seen);
    end
  endtask

  task automatic test_strict_stall();
    logic [3:0] mask;
    for (int t = 0; t < 3; t++) begin
      mask = 4'($urandom_range(0, 6) * 2 + 1);
      do_reset();
      a_strict = 1'b1; a_vals = mask;
      repeat (60) step();
      build_exp(0, 1'b1, mask, 64);
      n_tests++;
      if (a_obs.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL strict_stall mask=%b: got %0d lines want %0d", mask, a_obs.size(),
                 exp_q.size());
      end else begin
        for (int k = 0; k < a_obs.size(); k++) begin
          n_tests++;
          if (a_obs[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL strict_stall line %0d: got %h want %h", k, a_obs[k], exp_q[k]);
          end
        end
      end
    end
  endtask

  task automatic test_random_rr();
    logic [3:0] mask;
    int lim;
    for (int t = 0; t < 3; t++) begin
      mask = 4'($urandom_range(1, 15));
      do_reset();
      a_strict = 1'b0; a_vals = mask;
      lim = cyc + 400;
      while (a_obs.size() < 12 && cyc < lim) begin
        a_drdy = ($urandom_range(0, 3) != 0);
        step();
      end
      a_drdy = 1'b1;
      build_exp(0, 1'b0, mask, 12);
      n_tests++;
      if (a_obs.size() < 12) begin
        n_fail++;
        $display("FAIL random_rr_count mask=%b: got %0d want 12", mask, a_obs.size());
      end else begin
        for (int k = 0; k < 12; k++) begin
          n_tests++;
          if (a_obs[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL random_rr line %0d: got %h want %h", k, a_obs[k], exp_q[k]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int lim;
    do_reset();
    a_strict = 1'b1; a_vals = 4'hF;
    lim = cyc + 20;
    while (a_dval !== 1'b1 && cyc < lim) step();
    a_drdy = 1'b0;
    repeat (10) step();
    n_tests++;
    if (a_acc !== 2 || a_rdys !== '0 || a_dval !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_hold: got accepted=%0d rdys=%b val=%b want 2 0000 1",
               a_acc, a_rdys, a_dval);
    end
`ifdef RS_LINE_ARB_STATS_EN
    n_tests++;
    if (a_stat_s !== 32'd10) begin
      n_fail++;
      $display("FAIL stat_stall: got %0d want 10", a_stat_s);
    end
`endif
    a_drdy = 1'b1;
    lim = cyc + 200;
    while (a_obs.size() < 16 && cyc < lim) step();
    build_exp(0, 1'b1, 4'hF, 16);
    n_tests++;
    if (a_obs.size() < 16) begin
      n_fail++;
      $display("FAIL backpressure_count: got %0d want 16", a_obs.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_tests++;
        if (a_obs[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL backpressure line %0d: got %h want %h", k, a_obs[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_rr_wrap3();
    int lim;
    do_reset();
    b_strict = 1'b0; b_vals = 3'b111;
    lim = cyc + 200;
    while (b_obs.size() < 20 && cyc < lim) step();
    build_exp(1, 1'b0, 4'b0111, 20);
    n_tests++;
    if (b_obs.size() < 20) begin
      n_fail++;
      $display("FAIL rr_wrap3_count: got %0d want 20", b_obs.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        n_tests++;
        if (b_obs[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL rr_wrap3 line %0d: got %h want %h", k, b_obs[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int lim;
    do_reset();
    b_strict = 1'b1; b_vals = 3'b111;
    lim = cyc + 100;
    while (b_sp[1] < 1 && cyc < lim) step();
    n_tests++;
    if (b_dval !== 1'b1 || b_rdys !== 3'b010) begin
      n_fail++;
      $display("FAIL midburst_pre: got val=%b rdys=%b want 1 010", b_dval, b_rdys);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (b_dval !== 1'b0 || b_rdys !== '0 || b_ddata !== '0 || b_id !== '0 ||
        b_last !== 1'b0) begin
      n_fail++;
      $display("FAIL midburst_async: got val=%b rdys=%b data=%h id=%0d last=%b want 0",
               b_dval, b_rdys, b_ddata, b_id, b_last);
    end
    do_reset();
    b_strict = 1'b1; b_vals = 3'b111;
    lim = cyc + 100;
    while (b_obs.size() < 4 && cyc < lim) step();
    build_exp(1, 1'b1, 4'b0111, 4);
    n_tests++;
    if (b_obs.size() < 4) begin
      n_fail++;
      $display("FAIL midburst_recover_count: got %0d want 4", b_obs.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (b_obs[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL midburst_recover line %0d: got %h want %h", k, b_obs[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    cyc = 0;
    a_vals = '0; b_vals = '0; a_drdy = 1'b1; b_drdy = 1'b1;
    a_strict = 1'b1; b_strict = 1'b1;
    a_datas = '0; a_pars = '0; b_datas = '0; b_pars = '0;
    test_reset();
    test_strict_all_valid();
    test_only_input2();
    test_strict_stall();
    test_random_rr();
    test_backpressure();
    test_rr_wrap3();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rs_line_burst_arbiter.md
# rs_line_burst_arbiter

- Parametrised N-to-1 line arbiter for the Reed-Solomon encoder datapath.
- Merges NUM_INPUTS encoder line streams onto one output, in bursts of NUM_LINES lines per input. Lines are never interleaved within a burst.
- Two selection modes: strict index order for deterministic stripe layout, or work-conserving round-robin.
- Output side has an internal FIFO and tags every line with its source ID and an end-of-burst flag. It replaces fixed-radix reducer trees at the encoder output.

## Interface

Parameters:
- NUM_INPUTS, 32, number of input line streams; any value ≥2 (power of 2 not required)
- DATA_W, 256, line data width
- PARITY_W, 32, line parity width
- NUM_LINES, 4, lines per burst; ≥1
- FIFO_DEPTH, 2, output FIFO entries; power of 2, ≥2

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- strict_order  in  1  1 = strict index order, 0 = round-robin skipping idle inputs
- src_line_vals  in  NUM_INPUTS  per-input line valid
- src_line_datas  in  NUM_INPUTS×DATA_W  per-input data
- src_line_parities  in  NUM_INPUTS×PARITY_W  per-input parity
- src_line_rdys  out  NUM_INPUTS  per-input ready; at most one bit high
- dst_line_val  out  1  output valid
- dst_line_data  out  DATA_W  output data
- dst_line_parity  out  PARITY_W  output parity
- dst_line_src_id  out  max(1,$clog2(NUM_INPUTS))  source input index of the line
- dst_line_last  out  1  line is the final line of its burst
- dst_line_rdy  in  1  downstream ready
- stat_bursts, stat_stall_cycles  out  32 each  present only with the stats macro

## Operation

- Transfer rules:
  - Source handshake: val & rdy.
  - Destination handshake: dst_line_val & dst_line_rdy.
  - Sources must hold data stable while val is high.
- Registers:
  - state ∈ {IDLE, BURST}
  - cur (granted input)
  - next_ptr (search start)
  - line_cnt, width $clog2(NUM_LINES+1)
- IDLE:
  - Candidate selection: if strict_order=1, candidate = next_ptr and it must be valid. If strict_order=0, candidate = first valid input at or after next_ptr, cyclic.
  - If a candidate exists: cur←candidate, line_cnt←0, go to BURST. No source transfer happens in IDLE.
  - With no candidate, stay in IDLE.
- BURST:
  - src_line_rdys[cur] = FIFO not full; all other rdys are 0.
  - Each accepted line pushes {data, parity, cur, last} into the FIFO, with last = (line_cnt==NUM_LINES-1), then line_cnt increments.
  - On the last line: go to IDLE, next_ptr←(cur+1) with wrap from NUM_INPUTS-1 to 0.
- strict_order is sampled only in IDLE. A change mid-burst takes effect at the next selection.
- Strict mode waits indefinitely on an absent input; it never skips.
- FIFO:
  - Registered head drives the dst outputs.
  - Full: rdy=0 even if a pop happens the same cycle, so there is no combinational path from dst_line_rdy to src_line_rdys.
  - Empty: dst_line_val=0.
  - A push and a pop in the same cycle, when not full, are both performed.
- Reset (asserted at any time, including mid-burst):
  - state=IDLE, next_ptr=0, line_cnt=0, FIFO emptied.
  - All outputs go to 0 asynchronously, including data, parity, src_id and last.
  - A partially forwarded burst is abandoned; recovery is the source's responsibility.

## Timing

- Latency: a line accepted at a source in cycle t is visible on dst in cycle t+1.
- Per-burst overhead: one IDLE selection cycle. Throughput is NUM_LINES/(NUM_LINES+1) lines per cycle when dst is always ready.
- In BURST with an unblocked FIFO, one line per cycle.
- rdy depends only on registered state.

## Configuration

- RS_LINE_ARB_STATS_EN:
  - Defined: adds the stat_bursts and stat_stall_cycles ports.
  - stat_bursts counts completed bursts.
  - stat_stall_cycles counts cycles where dst_line_val=1 and dst_line_rdy=0.
  - Both counters are 32-bit, saturating, and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan

- NUM_INPUTS=4, NUM_LINES=2, strict_order=1, all inputs always valid, dst_rdy=1:
  - dst_line_src_id sequence 0,0,1,1,2,2,3,3,0,…
  - last=1 on every second line.
  - One idle bubble after each pair; data matches sources exactly.
- Only input 2 valid, NUM_INPUTS=4:
  - strict_order=0: back-to-back bursts from input 2 only.
  - strict_order=1: no output; src_line_rdys stay 0.
- FIFO_DEPTH=2, dst_rdy=0 for 10 cycles mid-burst:
  - Exactly 2 lines accepted, then rdy=0.
  - After release, all lines delivered in order with no loss or duplicate.
  - With stats enabled, stat_stall_cycles=10.
- NUM_INPUTS=3, round-robin, all valid: grant order 0,1,2,0; wrap is correct for a non-power-of-2 count.
- NUM_LINES=4, assert rst after 1 line of the burst from input 1:
  - dst_line_val and src_line_rdys drop to 0 in the same cycle.
  - After release, the first burst starts at input 0 and carries 4 lines with last on the 4th.
